// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - digit-scan prescaler with frame-synchronous commit of display values
// Optional digit blanking is enabled by defining SCAN_BLANK_EN.
module display_scan_ctrl #(
    parameter int DIV_WIDTH    = 17,
    parameter int DIV_COUNT    = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic        selector_in,
    input  logic [9:0]  corriente_in,
    input  logic [7:0]  frecuencia_in,
    output logic        selector,
    output logic [9:0]  corriente,
    output logic [7:0]  frecuencia,
    output logic [1:0]  cont,
    output logic        frame_tick,
    output logic        blank
);

    localparam logic [DIV_WIDTH-1:0] LAST = DIV_WIDTH'(DIV_COUNT - 1);

    logic [DIV_WIDTH-1:0] prescaler;
    logic [DIV_WIDTH-1:0] prescaler_nxt;
    logic                 tick;
    logic                 commit;
    logic                 transfer;
    logic                 pend_full;
    logic                 pend_sel;
    logic [9:0]           pend_cor;
    logic [7:0]           pend_fre;

    assign tick          = (prescaler == LAST);
    assign prescaler_nxt = tick ? '0 : prescaler + 1'b1;
    // Commit only on the edge where cont wraps, so a frame never mixes old and new digits
    assign commit        = tick && (cont == 2'b11) && pend_full;
    assign transfer      = upd_valid && !pend_full;
    assign upd_ready     = !pend_full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler  <= '0;
            cont       <= 2'b00;
            frame_tick <= 1'b0;
            pend_full  <= 1'b0;
            pend_sel   <= 1'b0;
            pend_cor   <= '0;
            pend_fre   <= '0;
            selector   <= 1'b0;
            corriente  <= '0;
            frecuencia <= '0;
        end else begin
            prescaler  <= prescaler_nxt;
            frame_tick <= tick && (cont == 2'b11);
            if (tick) begin
                cont <= cont + 2'd1;
            end
            if (transfer) begin
                pend_sel  <= selector_in;
                pend_cor  <= corriente_in;
                pend_fre  <= frecuencia_in;
                pend_full <= 1'b1;
            end else if (commit) begin
                pend_full <= 1'b0;
            end
            if (commit) begin
                selector   <= pend_sel;
                corriente  <= pend_cor;
                frecuencia <= pend_fre;
            end
        end
    end

`ifdef SCAN_BLANK_EN
    logic blank_r;

    // Registered from the next prescaler value so blank lines up with cont
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blank_r <= (BLANK_CYCLES > 0);
        end else begin
            blank_r <= (prescaler_nxt < DIV_WIDTH'(BLANK_CYCLES));
        end
    end

    assign blank = blank_r;
`else
    assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - scoreboard bench for display_scan_ctrl
module tb_display_scan_ctrl;

    localparam int DW = 3;
    localparam int DC = 4;
    localparam int BC = 1;
    localparam int FRAME = 4 * DC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       upd_valid = 1'b0;
    logic       upd_ready;
    logic       selector_in = 1'b0;
    logic [9:0] corriente_in = '0;
    logic [7:0] frecuencia_in = '0;
    logic       selector;
    logic [9:0] corriente;
    logic [7:0] frecuencia;
    logic [1:0] cont;
    logic       frame_tick;
    logic       blank;

    display_scan_ctrl #(.DIV_WIDTH(DW), .DIV_COUNT(DC), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .selector_in(selector_in), .corriente_in(corriente_in), .frecuencia_in(frecuencia_in),
        .selector(selector), .corriente(corriente), .frecuencia(frecuencia),
        .cont(cont), .frame_tick(frame_tick), .blank(blank)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sel;
        logic [9:0] cor;
        logic [7:0] fre;
        int         cap;
    } upd_t;

    upd_t       q[$];
    int         t = 0;
    int         checks = 0;
    int         errors = 0;
    bit         done = 1'b0;
    logic       m_sel = 1'b0;
    logic [9:0] m_cor = '0;
    logic [7:0] m_fre = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d actual=%0d expected=%0d", name, t, act, exp);
        end
    endtask

    // Monitor: t counts edges since the last reset edge; accepted values are displayed
    // from the first frame boundary after their capture edge.
    always @(posedge clk) begin
        upd_t h;
        if (!rst_n) begin
            t = 0;
            q.delete();
            m_sel = 1'b0;
            m_cor = '0;
            m_fre = '0;
        end else begin
            t++;
            if (t % FRAME == 0 && q.size() > 0 && q[0].cap < t) begin
                h = q.pop_front();
                m_sel = h.sel;
                m_cor = h.cor;
                m_fre = h.fre;
            end
        end
        #1;
        if (!done) begin
            chk("cont", 32'(cont), 32'((t / DC) % 4));
            chk("frame_tick", 32'(frame_tick), 32'(t > 0 && t % FRAME == 0));
            chk("upd_ready", 32'(upd_ready), 32'(q.size() == 0));
            chk("selector", 32'(selector), 32'(m_sel));
            chk("corriente", 32'(corriente), 32'(m_cor));
            chk("frecuencia", 32'(frecuencia), 32'(m_fre));
`ifdef SCAN_BLANK_EN
            chk("blank", 32'(blank), 32'((t % DC) < BC));
`else
            chk("blank", 32'(blank), 32'd0);
`endif
        end
    end

    // Called only at a negedge; a value seen as accepted is captured on the next edge (t+1).
    task automatic drive(input logic v, input logic s, input logic [9:0] c, input logic [7:0] f);
        upd_valid     = v;
        selector_in   = s;
        corriente_in  = c;
        frecuencia_in = f;
        if (rst_n && v && upd_ready) q.push_back('{s, c, f, t + 1});
    endtask

    task automatic send(input logic s, input logic [9:0] c, input logic [7:0] f);
        bit acc = 1'b0;
        for (int i = 0; i < 5 * FRAME; i++) begin
            acc = rst_n && upd_ready;
            drive(1'b1, s, c, f);
            @(negedge clk);
            if (acc) break;
        end
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout t=%0d actual=stalled expected=accepted", t);
        end
        drive(1'b0, 1'b0, '0, '0);
    endtask

    task automatic idle_to(input int ph);
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (t % FRAME == ph) return;
            @(negedge clk);
        end
        errors++;
        $display("FAIL idle_to_timeout t=%0d actual=%0d expected=%0d", t, t % FRAME, ph);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic       v = 1'b0;
        logic       s = 1'b0;
        logic [9:0] c = '0;
        logic [7:0] f = '0;
        bit         hold = 1'b0;
        bit         acc;

        do_reset();
        repeat (2 * FRAME + 3) @(negedge clk);

        idle_to(4);
        send(1'b1, 10'd500, 8'd0);
        idle_to(1);

        idle_to(2);
        send(1'b0, 10'd0, 8'd125);
        send(1'b0, 10'd0, 8'd250);
        idle_to(4);

        send(1'b1, 10'd7, 8'd9);
        idle_to(15);
        send(1'b0, 10'd3, 8'd200);
        idle_to(2);
        idle_to(2 + 1);

        idle_to(4);
        send(1'b1, 10'd999, 8'd77);
        idle_to(8);
        do_reset();
        repeat (2 * FRAME + 2) @(negedge clk);

        for (int i = 0; i < 600; i++) begin
            if (!hold) begin
                v = ($urandom_range(0, 2) == 0);
                s = 1'($urandom);
                c = 10'($urandom);
                f = 8'($urandom);
            end
            acc = upd_ready;
            drive(v, s, c, f);
            hold = v && !acc;
            @(negedge clk);
        end
        drive(1'b0, 1'b0, '0, '0);
        repeat (2 * FRAME) @(negedge clk);

        done = 1'b1;
        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
